// File: rtl/ber_readout_pkg.sv
// Shared opcode, word-index and width defaults for the BER readout block.
package ber_readout_pkg;

    localparam int unsigned DATA_W_DEF        = 32;
    localparam int unsigned REG_COUNT_LEN_DEF = 64;
    localparam int unsigned OPC_W             = 8;
    localparam int unsigned IDX_W             = 3;

    localparam logic [OPC_W-1:0] OP_CLEAR     = 8'h01;
    localparam logic [OPC_W-1:0] OP_SET_EN    = 8'h02;
    localparam logic [OPC_W-1:0] OP_SET_PHASE = 8'h03;
    localparam logic [OPC_W-1:0] OP_SNAPSHOT  = 8'h04;
    localparam logic [OPC_W-1:0] OP_READ      = 8'h05;
    localparam logic [OPC_W-1:0] OP_ERR_TAG   = 8'hFF;

    // Shadow word indices: bit 0 selects the high half, bits [2:1] the counter.
    localparam logic [IDX_W-1:0] WORD_ERR_R_LO = 3'd0;
    localparam logic [IDX_W-1:0] WORD_ERR_R_HI = 3'd1;
    localparam logic [IDX_W-1:0] WORD_ERR_I_LO = 3'd2;
    localparam logic [IDX_W-1:0] WORD_ERR_I_HI = 3'd3;
    localparam logic [IDX_W-1:0] WORD_BIT_R_LO = 3'd4;
    localparam logic [IDX_W-1:0] WORD_BIT_R_HI = 3'd5;
    localparam logic [IDX_W-1:0] WORD_BIT_I_LO = 3'd6;
    localparam logic [IDX_W-1:0] WORD_BIT_I_HI = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/ber_snapshot.sv
// Atomic shadow copy of the four BER counters plus the host word read mux.
module ber_snapshot
    import ber_readout_pkg::*;
#(
    parameter int unsigned REG_COUNT_LEN = REG_COUNT_LEN_DEF,
    parameter int unsigned DATA_W        = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [IDX_W-1:0]         idx,
    input  logic [REG_COUNT_LEN-1:0] error_count_r,
    input  logic [REG_COUNT_LEN-1:0] error_count_i,
    input  logic [REG_COUNT_LEN-1:0] bit_count_r,
    input  logic [REG_COUNT_LEN-1:0] bit_count_i,
    output logic [DATA_W-1:0]        rd_word_c
);

    logic [REG_COUNT_LEN-1:0] shadow_q [4];
    logic [REG_COUNT_LEN-1:0] sel_c;

    // All four shadows load on the same edge so a read-out set is coherent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else if (load) begin
            shadow_q[0] <= error_count_r;
            shadow_q[1] <= error_count_i;
            shadow_q[2] <= bit_count_r;
            shadow_q[3] <= bit_count_i;
        end
    end

    always_comb begin
        sel_c     = shadow_q[idx[2:1]];
        rd_word_c = idx[0] ? sel_c[2*DATA_W-1 -: DATA_W] : sel_c[DATA_W-1:0];
    end

endmodule

// File: rtl/ber_readout.sv
// Host command interface for BER counters: enables, phase, snapshot and word read-back.
module ber_readout
    import ber_readout_pkg::*;
#(
    parameter int unsigned REG_COUNT_LEN = REG_COUNT_LEN_DEF,
    parameter int unsigned DATA_W        = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_valid,
    input  logic [DATA_W-1:0]        i_cmd,
    output logic                     o_cmd_ready,
    input  logic [REG_COUNT_LEN-1:0] i_error_count_r,
    input  logic [REG_COUNT_LEN-1:0] i_error_count_i,
    input  logic [REG_COUNT_LEN-1:0] i_bit_count_r,
    input  logic [REG_COUNT_LEN-1:0] i_bit_count_i,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_data_valid,
    output logic                     o_error,
    output logic                     o_enable_tx,
    output logic                     o_enable_rx,
    output logic                     o_enable_ber,
    output logic [1:0]               o_phase
);

    localparam int unsigned ARG_W = DATA_W - OPC_W;
    localparam int unsigned PAD_W = DATA_W - 2*OPC_W;

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   op_in, op_q;
    logic [IDX_W-1:0]   idx_q;
    logic               accept_c, snap_load_c, resp_c, err_c;
    logic [DATA_W-1:0]  rd_word_c, resp_word_c;
    logic               unused_arg_c;

    assign op_in        = i_cmd[DATA_W-1 -: OPC_W];
    assign unused_arg_c = ^i_cmd[ARG_W-1:IDX_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_cmd_valid) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        accept_c    = 1'b0;
        snap_load_c = 1'b0;
        resp_c      = 1'b0;
        case (state_q)
            ST_IDLE:   accept_c = i_cmd_valid;
            ST_DECODE: begin
                snap_load_c = (op_q == OP_SNAPSHOT);
                resp_c      = 1'b1;
            end
            default: ;
        endcase
    end

    // Response word; unknown opcodes are tagged and flagged.
    always_comb begin
        resp_word_c = {op_q, ARG_W'(0)};
        err_c       = 1'b0;
        case (op_q)
            OP_CLEAR, OP_SET_EN, OP_SET_PHASE, OP_SNAPSHOT: ;
            OP_READ: resp_word_c = rd_word_c;
            default: begin
                resp_word_c = {OP_ERR_TAG, op_q, PAD_W'(0)};
                err_c       = 1'b1;
            end
        endcase
    end

    // Control registers take effect on the accept edge so they are live during DECODE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q         <= '0;
            idx_q        <= '0;
            o_cmd_ready  <= 1'b1;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_error      <= 1'b0;
            o_enable_tx  <= 1'b0;
            o_enable_rx  <= 1'b0;
            o_enable_ber <= 1'b0;
            o_phase      <= 2'd0;
        end else begin
            o_cmd_ready  <= (state_d == ST_IDLE);
            o_data_valid <= resp_c;
            o_error      <= resp_c && err_c;
            if (resp_c) o_data <= resp_word_c;
            if (accept_c) begin
                op_q  <= op_in;
                idx_q <= i_cmd[IDX_W-1:0];
                case (op_in)
                    OP_CLEAR: begin
                        o_enable_tx  <= 1'b0;
                        o_enable_rx  <= 1'b0;
                        o_enable_ber <= 1'b0;
                        o_phase      <= 2'd0;
                    end
                    OP_SET_EN:    {o_enable_ber, o_enable_rx, o_enable_tx} <= i_cmd[2:0];
                    OP_SET_PHASE: o_phase <= i_cmd[1:0];
                    default: ;
                endcase
            end
        end
    end

    ber_snapshot #(
        .REG_COUNT_LEN (REG_COUNT_LEN),
        .DATA_W        (DATA_W)
    ) u_snapshot (
        .clk           (clk),
        .rst           (rst),
        .load          (snap_load_c),
        .idx           (idx_q),
        .error_count_r (i_error_count_r),
        .error_count_i (i_error_count_i),
        .bit_count_r   (i_bit_count_r),
        .bit_count_i   (i_bit_count_i),
        .rd_word_c     (rd_word_c)
    );

endmodule

// File: tb/tb_ber_readout.sv
// Scoreboard bench for ber_readout: directed commands queue expected responses, a monitor checks them.
module tb_ber_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cmd_valid;
    logic [31:0] i_cmd;
    logic        o_cmd_ready;
    logic [63:0] i_error_count_r, i_error_count_i, i_bit_count_r, i_bit_count_i;
    logic [31:0] o_data;
    logic        o_data_valid, o_error;
    logic        o_enable_tx, o_enable_rx, o_enable_ber;
    logic [1:0]  o_phase;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [2:0]  en;
        logic [1:0]  phase;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ber_readout dut (
        .clk             (clk),
        .rst             (rst),
        .i_cmd_valid     (i_cmd_valid),
        .i_cmd           (i_cmd),
        .o_cmd_ready     (o_cmd_ready),
        .i_error_count_r (i_error_count_r),
        .i_error_count_i (i_error_count_i),
        .i_bit_count_r   (i_bit_count_r),
        .i_bit_count_i   (i_bit_count_i),
        .o_data          (o_data),
        .o_data_valid    (o_data_valid),
        .o_error         (o_error),
        .o_enable_tx     (o_enable_tx),
        .o_enable_rx     (o_enable_rx),
        .o_enable_ber    (o_enable_ber),
        .o_phase         (o_phase)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && o_data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data 0x%0h with nothing queued", o_data);
            end else begin
                e = sb.pop_front();
                check("resp_data", 64'(o_data), 64'(e.data));
                check("resp_error", 64'(o_error), 64'(e.err));
                check("resp_enables", 64'({o_enable_ber, o_enable_rx, o_enable_tx}), 64'(e.en));
                check("resp_phase", 64'(o_phase), 64'(e.phase));
            end
        end else if (o_error) begin
            checks++;
            errors++;
            $display("FAIL stray_error: got o_error=1 without o_data_valid, expected 0");
        end
    end

    // Issues one command from a negedge; returns at the negedge of the DECODE cycle.
    task automatic issue(input logic [7:0] op, input logic [23:0] arg, input logic expect_resp,
                         input logic [31:0] ed, input logic ee, input logic [2:0] een,
                         input logic [1:0] eph);
        int n = 0;
        while (!o_cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_cmd_ready) begin
            check("ready_timeout", 64'(o_cmd_ready), 64'd1);
            return;
        end
        if (expect_resp) sb.push_back('{data: ed, err: ee, en: een, phase: eph});
        i_cmd_valid = 1'b1;
        i_cmd       = {op, arg};
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
        i_cmd       = 32'h01FF_FFFF;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(o_cmd_ready), 64'd1);
        check({tag, "_data"}, 64'(o_data), 64'd0);
        check({tag, "_valid"}, 64'(o_data_valid), 64'd0);
        check({tag, "_error"}, 64'(o_error), 64'd0);
        check({tag, "_enables"}, 64'({o_enable_ber, o_enable_rx, o_enable_tx}), 64'd0);
        check({tag, "_phase"}, 64'(o_phase), 64'd0);
    endtask

    initial begin
        int acc;
        int n;
        rst             = 1'b0;
        i_cmd_valid     = 1'b0;
        i_cmd           = '0;
        i_error_count_r = 64'h0000_0005_0000_0009;
        i_error_count_i = 64'hAAAA_BBBB_CCCC_DDDD;
        i_bit_count_r   = 64'h1111_2222_3333_4444;
        i_bit_count_i   = 64'h1234_5678_9ABC_DEF0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // SET_EN: enables live in DECODE, response in the following cycle.
        issue(8'h02, 24'h000007, 1'b1, 32'h0200_0000, 1'b0, 3'b111, 2'd0);
        check("set_en_cycle1_enables", 64'({o_enable_ber, o_enable_rx, o_enable_tx}), 64'h7);
        check("set_en_cycle1_no_valid", 64'(o_data_valid), 64'd0);
        @(negedge clk);
        check("set_en_cycle2_valid", 64'(o_data_valid), 64'd1);

        issue(8'h03, 24'h000003, 1'b1, 32'h0300_0000, 1'b0, 3'b111, 2'd3);
        issue(8'h01, 24'h000000, 1'b1, 32'h0100_0000, 1'b0, 3'b000, 2'd0);

        // READ before any SNAPSHOT returns zero.
        issue(8'h05, 24'h000003, 1'b1, 32'h0000_0000, 1'b0, 3'b000, 2'd0);

        issue(8'h04, 24'h000000, 1'b1, 32'h0400_0000, 1'b0, 3'b000, 2'd0);
        @(negedge clk);
        i_error_count_r = '1;
        i_error_count_i = '1;
        i_bit_count_r   = '1;
        i_bit_count_i   = '1;
        issue(8'h05, 24'h000000, 1'b1, 32'h0000_0009, 1'b0, 3'b000, 2'd0);
        issue(8'h05, 24'h000001, 1'b1, 32'h0000_0005, 1'b0, 3'b000, 2'd0);
        issue(8'h05, 24'h000006, 1'b1, 32'h9ABC_DEF0, 1'b0, 3'b000, 2'd0);
        issue(8'h05, 24'h000007, 1'b1, 32'h1234_5678, 1'b0, 3'b000, 2'd0);
        issue(8'h05, 24'h000002, 1'b1, 32'hCCCC_DDDD, 1'b0, 3'b000, 2'd0);
        issue(8'h05, 24'h000005, 1'b1, 32'h1111_2222, 1'b0, 3'b000, 2'd0);
        issue(8'h05, 24'hABCF0E, 1'b1, 32'h9ABC_DEF0, 1'b0, 3'b000, 2'd0);

        // Unknown opcode flags an error and leaves the enables alone.
        issue(8'h02, 24'h000005, 1'b1, 32'h0200_0000, 1'b0, 3'b101, 2'd0);
        issue(8'h7E, 24'h000000, 1'b1, 32'hFF7E_0000, 1'b1, 3'b101, 2'd0);
        issue(8'h00, 24'h000003, 1'b1, 32'hFF00_0000, 1'b1, 3'b101, 2'd0);

        // Valid held high: accepts on every third cycle only.
        n = 0;
        while (!o_cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 3; k++) sb.push_back('{data: 32'h0300_0000, err: 1'b0, en: 3'b101, phase: 2'd2});
        i_cmd_valid = 1'b1;
        i_cmd       = 32'h0300_0002;
        acc         = 0;
        for (int c = 0; c < 9; c++) begin
            check("held_valid_ready", 64'(o_cmd_ready), 64'((c % 3) == 0));
            if (o_cmd_ready) acc++;
            @(negedge clk);
        end
        i_cmd_valid = 1'b0;
        check("held_valid_accepts", 64'(acc), 64'd3);

        // Reset pulsed during DECODE aborts the command with no response.
        issue(8'h02, 24'h000003, 1'b0, 32'h0, 1'b0, 3'b000, 2'd0);
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("abort_no_valid", 64'(o_data_valid), 64'd0);
            @(negedge clk);
        end
        check_reset_outputs("after_abort");

        // Reset also clears the shadows.
        issue(8'h05, 24'h000006, 1'b1, 32'h0000_0000, 1'b0, 3'b000, 2'd0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ber_readout.md
BER_READOUT -- requirements
Module: ber_readout

Interface
REQ-001 SHALL have parameter REG_COUNT_LEN, default 64: width of each BER counter input.
REQ-002 SHALL have parameter DATA_W, default 32: host command/response word width; REG_COUNT_LEN = 2*DATA_W.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_cmd_valid  in  1  host command present.
REQ-006 SHALL have port i_cmd  in  DATA_W  command: opcode [31:24], argument [23:0].
REQ-007 SHALL have port o_cmd_ready  out  1  block can accept a command.
REQ-008 SHALL have ports i_error_count_r, i_error_count_i, i_bit_count_r, i_bit_count_i  in  REG_COUNT_LEN each  live BER counters.
REQ-009 SHALL have port o_data  out  DATA_W  response word.
REQ-010 SHALL have port o_data_valid  out  1  one-cycle response strobe.
REQ-011 SHALL have port o_error  out  1  one-cycle strobe, coincident with o_data_valid, for unknown opcode.
REQ-012 SHALL have ports o_enable_tx, o_enable_rx, o_enable_ber  out  1 each  datapath enables.
REQ-013 SHALL have port o_phase  out  2  receiver sampling phase.

Function
REQ-014 SHALL implement FSM IDLE -> DECODE -> RESP -> IDLE; o_cmd_ready high only in IDLE.
REQ-015 SHALL accept a command when i_cmd_valid && o_cmd_ready (cycle 0); capture i_cmd into a command register; go to DECODE at cycle 1, RESP at cycle 2, IDLE at cycle 3.
REQ-016 SHALL assert o_data_valid for exactly one cycle, in RESP (2 cycles after accept); o_data held from RESP until the next RESP.
REQ-017 SHALL ignore i_cmd_valid and i_cmd while not in IDLE; host holds valid until accepted.
REQ-018 Opcode 0x01 CLEAR SHALL set all enables and o_phase to 0 in DECODE.
REQ-019 Opcode 0x02 SET_EN SHALL load {o_enable_ber, o_enable_rx, o_enable_tx} from arg[2:0] in DECODE.
REQ-020 Opcode 0x03 SET_PHASE SHALL load o_phase from arg[1:0] in DECODE.
REQ-021 Opcode 0x04 SNAPSHOT SHALL latch all four counter inputs into shadow registers in the same DECODE cycle (atomic).
REQ-022 Opcode 0x05 READ SHALL return shadow word arg[2:0]: 0/1 error_r lo/hi, 2/3 error_i lo/hi, 4/5 bit_r lo/hi, 6/7 bit_i lo/hi; arg[23:3] ignored.
REQ-023 Non-READ valid opcodes SHALL respond o_data = {opcode, 24'h0}.
REQ-024 Any other opcode SHALL respond o_data = {8'hFF, opcode, 16'h0} with o_error high; no state change.
REQ-025 READ before any SNAPSHOT SHALL return 0; shadows change only on SNAPSHOT, never from live counters.
REQ-026 Back-to-back commands SHALL be accepted no faster than one per 3 cycles; cycle 3 accept allowed.

Reset
REQ-027 rst low SHALL asynchronously force: FSM IDLE, o_cmd_ready 1, o_data 0, o_data_valid 0, o_error 0, all enables 0, o_phase 0, shadows 0, command register 0.
REQ-028 Reset mid-command SHALL abort it with no response strobe after release.

Structure
REQ-029 Opcodes, word-index constants, REG_COUNT_LEN and DATA_W defaults SHALL live in a shared package/include alongside the existing DSP defines.
REQ-030 Shadow registers and word mux SHALL be one sub-module, ber_snapshot (load strobe, 3-bit index, 4 counter inputs, DATA_W output).

Verification
REQ-031 Reset, then SET_EN 0x000007 -> enables 1,1,1 at cycle 1; o_data 0x02000000 valid at cycle 2.
REQ-032 SET_PHASE 0x000003 then CLEAR -> o_phase 3 then 0; all enables 0.
REQ-033 Counters error_r=0x0000000500000009, bit_i=0x123456789ABCDEF0; SNAPSHOT; change inputs; READ 0,1,6,7 -> 0x00000009, 0x00000005, 0x9ABCDEF0, 0x12345678.
REQ-034 READ idx 3 after reset with no SNAPSHOT -> 0x00000000.
REQ-035 Opcode 0x7E -> o_data 0xFF7E0000, o_error 1 one cycle, enables unchanged.
REQ-036 i_cmd_valid held continuously -> accepts every 3rd cycle; rst pulsed in DECODE -> no o_data_valid, outputs at reset values.
